// File: rtl/m_stage_wreg_if.sv
// m_stage_wreg_if: M-register inputs, memory-stage forwarding outputs and the W
// register bundle, grouped for the memory stage / W register block.
// The master side is the pipeline (drives M_* and W control), and the slave side is the stage.
interface m_stage_wreg_if;
    logic        W_stall;
    logic        W_bubble;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    modport master (
        output W_stall, W_bubble, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    modport slave (
        input  W_stall, W_bubble, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/m_stage_wreg.sv
// m_stage_wreg: Y86-64 memory stage (byte-addressed little-endian data memory)
// followed by the W pipeline register.
// Optional feature macro: M_ALIGN_CHECK_EN -- when defined, any data access whose
// address is not 8-byte aligned raises an address error (ADR).
module m_stage_wreg #(
    parameter int unsigned DMEM_BYTES = 1024
) (
    input logic           clk,
    input logic           rst_n,
    m_stage_wreg_if.slave bus
);
    localparam int unsigned AW       = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;
    // Highest legal start address of an 8-byte access.
    localparam logic [63:0] LastAddr = 64'(DMEM_BYTES) - 64'd8;

    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;
    localparam logic [3:0] INop    = 4'h1;

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatAdr = 2'd2;

    logic [7:0]  mem_q [DMEM_BYTES];
    logic [63:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        dmem_error;
    logic        mem_we;
    logic [63:0] rd_data;

    logic [1:0]  w_stat_q;
    logic [3:0]  w_icode_q;
    logic [63:0] w_valE_q;
    logic [63:0] w_valM_q;
    logic [3:0]  w_dstE_q;
    logic [3:0]  w_dstM_q;

    // Condition flag travels with M but has no consumer past this stage.
    logic unused_cnd;
    assign unused_cnd = bus.M_cnd;

    function automatic logic [AW-1:0] byte_idx(input logic [63:0] base, input int unsigned ofs);
        return base[AW-1:0] + AW'(ofs);
    endfunction

    // Decode access type and pick the address source from icode.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        case (bus.M_icode)
            IRmmovq, ICall, IPushq: begin
                mem_write = 1'b1;
                mem_addr  = bus.M_valE;
            end
            IMrmovq: begin
                mem_read = 1'b1;
                mem_addr = bus.M_valE;
            end
            IRet, IPopq: begin
                mem_read = 1'b1;
                mem_addr = bus.M_valA;
            end
            default: ;
        endcase
    end

    // Full-width unsigned bound check so addresses near 2^64 cannot wrap into range.
    always_comb begin
        dmem_error = (mem_read || mem_write) && (mem_addr > LastAddr);
`ifdef M_ALIGN_CHECK_EN
        if ((mem_read || mem_write) && (mem_addr[2:0] != 3'd0)) begin
            dmem_error = 1'b1;
        end
`endif
    end

    // Assemble the little-endian word starting at mem_addr (any byte alignment).
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            rd_data[8*i +: 8] = mem_q[byte_idx(mem_addr, i)];
        end
    end

    assign bus.m_valM = (mem_read && !dmem_error) ? rd_data : '0;
    assign bus.m_stat = dmem_error ? StatAdr : bus.M_stat;

    // A store behind a halted/faulting instruction in W must not land.
    assign mem_we = mem_write && !dmem_error && (bus.M_stat == StatAok) && (w_stat_q == StatAok);

    // Data memory write; contents survive reset, only the write itself is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                mem_q[byte_idx(mem_addr, i)] <= bus.M_valA[8*i +: 8];
            end
        end
    end

    // W pipeline register: reset/bubble load a nop, stall has priority over bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stat_q  <= StatAok;
            w_icode_q <= INop;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
            w_dstE_q  <= 4'hF;
            w_dstM_q  <= 4'hF;
        end else if (bus.W_stall) begin
            w_stat_q  <= w_stat_q;
            w_icode_q <= w_icode_q;
            w_valE_q  <= w_valE_q;
            w_valM_q  <= w_valM_q;
            w_dstE_q  <= w_dstE_q;
            w_dstM_q  <= w_dstM_q;
        end else if (bus.W_bubble) begin
            w_stat_q  <= StatAok;
            w_icode_q <= INop;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
            w_dstE_q  <= 4'hF;
            w_dstM_q  <= 4'hF;
        end else begin
            w_stat_q  <= bus.m_stat;
            w_icode_q <= bus.M_icode;
            w_valE_q  <= bus.M_valE;
            w_valM_q  <= bus.m_valM;
            w_dstE_q  <= bus.M_dstE;
            w_dstM_q  <= bus.M_dstM;
        end
    end

    assign bus.W_stat  = w_stat_q;
    assign bus.W_icode = w_icode_q;
    assign bus.W_valE  = w_valE_q;
    assign bus.W_valM  = w_valM_q;
    assign bus.W_dstE  = w_dstE_q;
    assign bus.W_dstM  = w_dstM_q;
endmodule

// File: tb/tb_m_stage_wreg.sv
// tb_m_stage_wreg: directed stimulus for m_stage_wreg (DMEM_BYTES = 1024) with a
// byte-array reference model checked every cycle, plus hand-computed literal checks.
module tb_m_stage_wreg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    m_stage_wreg_if bus ();

    m_stage_wreg #(
        .DMEM_BYTES (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model state: memory image and expected W register.
    logic [7:0]  mdl_mem [1024];
    logic [1:0]  e_stat;
    logic [3:0]  e_icode;
    logic [63:0] e_valE;
    logic [63:0] e_valM;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;

    function automatic logic [63:0] pat(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k);
    endfunction

    function automatic bit is_rd(input logic [3:0] ic);
        return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    endfunction

    function automatic bit is_wr(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    endfunction

    function automatic logic [63:0] addr_of(input logic [3:0] ic, input logic [63:0] ve,
                                            input logic [63:0] va);
        return ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
    endfunction

    function automatic bit mdl_err(input logic [3:0] ic, input logic [63:0] ve,
                                   input logic [63:0] va);
        logic [63:0] a;
        bit bad;
        a = addr_of(ic, ve, va);
        bad = (a > 64'd1016);
`ifdef M_ALIGN_CHECK_EN
        if (a[2:0] != 3'd0) bad = 1'b1;
`endif
        return (is_rd(ic) || is_wr(ic)) && bad;
    endfunction

    function automatic logic [63:0] mdl_valM(input logic [3:0] ic, input logic [63:0] ve,
                                             input logic [63:0] va);
        logic [63:0] a;
        logic [63:0] r;
        r = '0;
        a = addr_of(ic, ve, va);
        if (is_rd(ic) && !mdl_err(ic, ve, va)) begin
            for (int i = 0; i < 8; i++) r[8*i +: 8] = mdl_mem[int'(a[9:0]) + i];
        end
        return r;
    endfunction

    function automatic logic [1:0] mdl_stat(input logic [3:0] ic, input logic [63:0] ve,
                                            input logic [63:0] va, input logic [1:0] st);
        return mdl_err(ic, ve, va) ? 2'd2 : st;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_stat  <= 2'd0;
            e_icode <= 4'h1;
            e_valE  <= '0;
            e_valM  <= '0;
            e_dstE  <= 4'hF;
            e_dstM  <= 4'hF;
        end else begin
            if (is_wr(bus.M_icode) && !mdl_err(bus.M_icode, bus.M_valE, bus.M_valA) &&
                bus.M_stat == 2'd0 && e_stat == 2'd0) begin
                for (int i = 0; i < 8; i++) begin
                    mdl_mem[int'(bus.M_valE[9:0]) + i] <= bus.M_valA[8*i +: 8];
                end
            end
            if (!bus.W_stall) begin
                if (bus.W_bubble) begin
                    e_stat  <= 2'd0;
                    e_icode <= 4'h1;
                    e_valE  <= '0;
                    e_valM  <= '0;
                    e_dstE  <= 4'hF;
                    e_dstM  <= 4'hF;
                end else begin
                    e_stat  <= mdl_stat(bus.M_icode, bus.M_valE, bus.M_valA, bus.M_stat);
                    e_icode <= bus.M_icode;
                    e_valE  <= bus.M_valE;
                    e_valM  <= mdl_valM(bus.M_icode, bus.M_valE, bus.M_valA);
                    e_dstE  <= bus.M_dstE;
                    e_dstM  <= bus.M_dstM;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valM", bus.m_valM, mdl_valM(bus.M_icode, bus.M_valE, bus.M_valA));
            check("m_stat", 64'(bus.m_stat),
                  64'(mdl_stat(bus.M_icode, bus.M_valE, bus.M_valA, bus.M_stat)));
            check("W_stat", 64'(bus.W_stat), 64'(e_stat));
            check("W_icode", 64'(bus.W_icode), 64'(e_icode));
            check("W_valE", bus.W_valE, e_valE);
            check("W_valM", bus.W_valM, e_valM);
            check("W_dstE", 64'(bus.W_dstE), 64'(e_dstE));
            check("W_dstM", 64'(bus.W_dstM), 64'(e_dstM));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        bus.M_stat  = st;
        bus.M_icode = ic;
        bus.M_valE  = ve;
        bus.M_valA  = va;
        bus.M_dstE  = de;
        bus.M_dstM  = dm;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mdl_mem[i] = 8'h00;
        e_stat = 2'd0; e_icode = 4'h1; e_valE = '0; e_valM = '0; e_dstE = 4'hF; e_dstM = 4'hF;
        bus.W_stall = 1'b0;
        bus.W_bubble = 1'b0;
        bus.M_cnd = 1'b0;
        set_m(2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset_W_icode", 64'(bus.W_icode), 64'h1);
        check("reset_W_dstE", 64'(bus.W_dstE), 64'hF);

        // Fill memory with a known pattern: word k = k * 0x1111...
        for (int k = 0; k < 128; k++) begin
            step();
            set_m(2'd0, 4'h4, 64'(k) * 64'd8, pat(k), 4'hF, 4'hF);
        end

        // Store then load.
        step(); set_m(2'd0, 4'h4, 64'h10, 64'h0123_4567_89AB_CDEF, 4'hF, 4'hF);
        step(); set_m(2'd0, 4'h5, 64'h10, 64'd0, 4'hF, 4'h3);
        #2;
        check("load_valM", bus.m_valM, 64'h0123_4567_89AB_CDEF);
        check("load_byte10", {56'd0, bus.m_valM[7:0]}, 64'hEF);
        step(); set_m(2'd0, 4'h5, 64'h11, 64'd0, 4'hF, 4'h4);
        #2;
        check("wb_valM", bus.W_valM, 64'h0123_4567_89AB_CDEF);
`ifdef M_ALIGN_CHECK_EN
        check("unaligned_stat", 64'(bus.m_stat), 64'd2);
        check("unaligned_valM", bus.m_valM, 64'd0);
`else
        check("unaligned_stat", 64'(bus.m_stat), 64'd0);
        check("unaligned_valM", bus.m_valM, 64'h3301_2345_6789_ABCD);
`endif

        // Bounds.
        step(); set_m(2'd0, 4'hB, 64'd0, 64'h3F8, 4'h4, 4'hF);
        #2; check("bound_3F8_stat", 64'(bus.m_stat), 64'd0);
        step(); set_m(2'd0, 4'hB, 64'd0, 64'h3F9, 4'h4, 4'hF);
        #2; check("bound_3F9_stat", 64'(bus.m_stat), 64'd2);
        check("bound_3F9_valM", bus.m_valM, 64'd0);
        step(); set_m(2'd0, 4'hA, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD, 4'h4, 4'hF);
        #2; check("wrap_push_stat", 64'(bus.m_stat), 64'd2);

        // Asynchronous reset mid-cycle.
        step(); set_m(2'd0, 4'h6, 64'h55, 64'd0, 4'h2, 4'hF);
        step(); set_m(2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        #1 check("pre_reset_valE", bus.W_valE, 64'h55);
        #1 rst_n = 1'b0;
        #1;
        check("rst_W_valE", bus.W_valE, 64'd0);
        check("rst_W_icode", 64'(bus.W_icode), 64'h1);
        check("rst_W_dstE", 64'(bus.W_dstE), 64'hF);
        check("rst_W_dstM", 64'(bus.W_dstM), 64'hF);
        rst_n = 1'b1;
        step(); set_m(2'd0, 4'h5, 64'h10, 64'd0, 4'hF, 4'h3);
        #2; check("mem_survives_reset", bus.m_valM, 64'h0123_4567_89AB_CDEF);

        // Store suppressed behind a halted instruction held in W.
        step(); set_m(2'd1, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF);
        step(); bus.W_stall = 1'b1; set_m(2'd0, 4'h8, 64'h20, 64'hAA, 4'h4, 4'hF);
        #2; check("halt_in_W", 64'(bus.W_stat), 64'd1);
        step(); set_m(2'd0, 4'h5, 64'h20, 64'd0, 4'hF, 4'hF);
        #2; check("store_suppressed", bus.m_valM, 64'h4444_4444_4444_4444);
        step(); step();
        #2;
        check("stall3_W_stat", 64'(bus.W_stat), 64'd1);
        check("stall3_W_icode", 64'(bus.W_icode), 64'h0);
        bus.W_bubble = 1'b1;
        step();
        #2; check("stall_beats_bubble", 64'(bus.W_icode), 64'h0);
        bus.W_stall = 1'b0;
        step();
        #2;
        check("bubble_W_icode", 64'(bus.W_icode), 64'h1);
        check("bubble_W_dstE", 64'(bus.W_dstE), 64'hF);
        check("bubble_W_stat", 64'(bus.W_stat), 64'd0);
        bus.W_bubble = 1'b0;
        set_m(2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/m_stage_wreg.md
Name: m_stage_wreg

Overview:
- Memory stage of the Y86-64 pipeline together with the W pipeline register.
- Consumes the M-register outputs (M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM).
- Contains the byte-addressed data memory. Produces the combinational m_valM/m_stat for forwarding and hazard control, and registers the write-back bundle into W_*.

Parameters:
- DMEM_BYTES, 1024, data memory size in bytes; must be a multiple of 8 and at least 8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- W_stall  in  1  hold W register contents.
- W_bubble  in  1  load bubble into W register.
- M_stat  in  2  stage status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- M_icode  in  4  instruction code.
- M_cnd  in  1  condition result; passed through.
- M_valE  in  64  ALU result or address.
- M_valA  in  64  store data or pop address.
- M_dstE  in  4  destination register for valE.
- M_dstM  in  4  destination register for valM.
- m_valM  out  64  combinational memory read data.
- m_stat  out  2  combinational stage status after the memory check.
- W_stat  out  2  registered status.
- W_icode  out  4  registered icode.
- W_valE  out  64  registered valE.
- W_valM  out  64  registered valM.
- W_dstE  out  4  registered dstE.
- W_dstM  out  4  registered dstM.

Behaviour:
- Address select: mem_addr = M_valE for icode 4 (rmmovq), 5 (mrmovq), 8 (call), A (pushq); mem_addr = M_valA for 9 (ret), B (popq); otherwise don't-care.
- mem_read = icode in {5, 9, B}. mem_write = icode in {4, 8, A}.
- Memory layout: 64-bit words, little-endian. Byte at mem_addr is bits [7:0].
- dmem_error = (mem_read | mem_write) and mem_addr > DMEM_BYTES-8, evaluated as a 64-bit unsigned compare, so addresses near 2^64 cannot wrap.
- m_valM = little-endian 8 bytes at mem_addr when mem_read and not dmem_error; otherwise 0. Purely combinational, zero latency.
- m_stat = 2 (ADR) if dmem_error, else M_stat.
- Write:
  - Occurs at posedge when mem_write, not dmem_error, M_stat == AOK and W_stat == AOK.
  - Data = M_valA; 8 bytes are written.
  - A store is therefore suppressed behind a halting or faulting instruction in W.
- Writes occur regardless of W_stall/W_bubble; the pipeline controller never stalls M with a store pending.
- W register at posedge, priority in this order:
  1. rst_n low: asynchronous load of the bubble value.
  2. W_stall: hold all W_* outputs.
  3. W_bubble: load the bubble value.
  4. Otherwise: W_stat <= m_stat, W_icode <= M_icode, W_valE <= M_valE, W_valM <= m_valM, W_dstE <= M_dstE, W_dstM <= M_dstM.
- Bubble/reset value: W_stat = 0, W_icode = 4'h1, W_valE = 0, W_valM = 0, W_dstE = 4'hF, W_dstM = 4'hF.
- W_stall and W_bubble both high: stall wins.
- Reset mid-operation:
  - W outputs clear immediately, asynchronously.
  - Memory contents are not reset.
  - Writes are blocked while rst_n is low.
- Read during a same-cycle write to the same address returns the old data; the write lands at the clock edge.
- M_cnd is accepted but not registered into W.

Optional Feature:
- Macro: M_ALIGN_CHECK_EN.
- Defined: dmem_error is also raised when (mem_read | mem_write) and mem_addr[2:0] != 0. Consequences: m_stat = ADR, m_valM = 0, and the write is suppressed.
- Undefined: unaligned accesses are legal and use 8 consecutive bytes starting at mem_addr.

Test Plan:
- Reset: hold rst_n low mid-cycle with W_valE = 0x55 -> all W_* take bubble values immediately (W_icode = 1, W_dstE = W_dstM = F).
- Store then load: icode 4, M_valE = 0x10, M_valA = 0x0123456789ABCDEF; next cycle icode 5, M_valE = 0x10 -> m_valM = 0x0123456789ABCDEF and byte 0x10 = 0xEF. Following edge: W_valM = 0x0123456789ABCDEF.
- Bounds (DMEM_BYTES = 1024):
  - icode B, M_valA = 0x3F8 -> m_stat = 0, valid read.
  - M_valA = 0x3F9 -> m_stat = 2, m_valM = 0.
  - icode A, M_valE = 0xFFFFFFFFFFFFFFF8 -> m_stat = 2, no write.
- Write suppression: W_stat = 1 (HLT) held by W_stall; icode 8 store of 0xAA to 0x20 -> memory at 0x20 unchanged on readback.
- Stall/bubble: W_stall = 1 -> W_* unchanged for 3 cycles; W_stall = W_bubble = 1 -> hold; W_bubble alone -> bubble values.
- With M_ALIGN_CHECK_EN: icode 5, M_valE = 0x12 -> m_stat = 2; the same access without the macro -> m_stat = 0 and unaligned data returned.
